// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths and requester encoding for the write-back arbiter
package wb_arbiter_pkg;
  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_e;
endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register outstanding-write scoreboard
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int NREGS = wb_arbiter_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_rd,
  output logic [NREGS-1:0]  pending
);

  logic [NREGS-1:0] pending_nxt;

  // Set is applied after clear so a same-cycle re-issue keeps the bit; x0 never tracks.
  always_comb begin
    pending_nxt = pending;
    if (clr_valid) pending_nxt[clr_rd] = 1'b0;
    if (issue_valid) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
    if (flush) pending_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin ALU/LSU write-back arbiter with registered RF write port
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = wb_arbiter_pkg::XLEN,
  parameter int NREGS = wb_arbiter_pkg::NREGS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [NREGS-1:0]  pending
);

  req_e              last_grant;
  logic              alu_win;
  logic              lsu_win;
  logic              accept;
  logic [REG_AW-1:0] acc_rd;
  logic [XLEN-1:0]   acc_data;

  // Under contention the side that did not win last time goes first.
  always_comb begin
    alu_win   = alu_valid && (!lsu_valid || (last_grant == REQ_LSU));
    lsu_win   = lsu_valid && !alu_win;
    alu_ready = alu_win && reset_n && !flush;
    lsu_ready = lsu_win && reset_n && !flush;
    accept    = alu_ready || lsu_ready;
    acc_rd    = alu_ready ? alu_rd : lsu_rd;
    acc_data  = alu_ready ? alu_data : lsu_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= REQ_LSU;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_we <= accept && (acc_rd != '0);
      if (accept) begin
        last_grant <= alu_ready ? REQ_ALU : REQ_LSU;
      end
      // Writes to x0 are swallowed; the write port keeps its previous address/data.
      if (accept && (acc_rd != '0)) begin
        rf_waddr <= acc_rd;
        rf_wdata <= acc_data;
      end
    end
  end

  wb_scoreboard #(
    .NREGS(NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .clr_valid  (rf_we),
    .clr_rd     (rf_waddr),
    .pending    (pending)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, lsu_valid, issue_valid, flush;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_ready, lsu_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pending;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .flush      (flush),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pending    (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: who may write, what lands on the write port, which registers are outstanding.
  bit        m_last_lsu;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  bit        m_pend [32];
  bit        mea, mel, cea, cel;
  bit [4:0]  m_rd;

  function automatic void exp_ready(output bit a, output bit l);
    a = 1'b0;
    l = 1'b0;
    if (reset_n && !flush) begin
      if (alu_valid && lsu_valid) begin
        a = m_last_lsu;
        l = !m_last_lsu;
      end else begin
        a = alu_valid;
        l = lsu_valid;
      end
    end
  endfunction

  function automatic logic [31:0] pend_word();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) w[i] = m_pend[i];
    return w;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_last_lsu = 1'b1;
      m_we       = 1'b0;
      m_waddr    = '0;
      m_wdata    = '0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      exp_ready(mea, mel);
      if (flush) begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
      end else begin
        if (m_we) m_pend[m_waddr] = 1'b0;
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
      end
      m_we = 1'b0;
      if (mea || mel) begin
        m_last_lsu = mel;
        m_rd = mea ? alu_rd : lsu_rd;
        if (m_rd != 0) begin
          m_we    = 1'b1;
          m_waddr = m_rd;
          m_wdata = mea ? alu_data : lsu_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_ready(cea, cel);
    check("cmp_alu_ready", alu_ready, cea);
    check("cmp_lsu_ready", lsu_ready, cel);
    check("cmp_rf_we", rf_we, m_we);
    check("cmp_rf_waddr", rf_waddr, m_waddr);
    check("cmp_rf_wdata", rf_wdata, m_wdata);
    check("cmp_pending", pending, pend_word());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid   = 1'b0;
    lsu_valid   = 1'b0;
    issue_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    alu_rd = 5'd3; alu_data = 32'h0; lsu_rd = 5'd0; lsu_data = 32'h0; issue_rd = 5'd0;
    alu_valid = 1'b1;
    step(); step();
    check("rst_alu_ready", alu_ready, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_pending", pending, 0);
    idle();
    reset_n = 1'b1;
    step();

    // single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("t035_alu_ready", alu_ready, 1);
    step(); idle();
    check("t035_rf_we", rf_we, 1);
    check("t035_rf_waddr", rf_waddr, 5);
    check("t035_rf_wdata", rf_wdata, 32'hDEADBEEF);
    step();
    check("t035_we_drop", rf_we, 0);
    check("t035_addr_hold", rf_waddr, 5);
    check("t035_data_hold", rf_wdata, 32'hDEADBEEF);

    // contention alternates starting with ALU after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA0 + i;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB0 + i;
      #1;
      check("t036_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
      check("t036_lsu_ready", lsu_ready, (i % 2 == 0) ? 0 : 1);
      step();
      check("t036_rf_waddr", rf_waddr, (i % 2 == 0) ? 1 : 2);
      check("t036_rf_wdata", rf_wdata, (i % 2 == 0) ? 32'hA0 + i : 32'hB0 + i);
    end
    idle();
    step();

    // write to x0 is consumed silently
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    #1 check("t037_lsu_ready", lsu_ready, 1);
    step(); idle();
    check("t037_rf_we", rf_we, 0);
    check("t037_pending", pending, 0);

    // issue then commit clears pending
    issue_valid = 1'b1; issue_rd = 5'd7;
    step(); idle();
    check("t038_pend_set", pending, 32'h80);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step(); idle();
    check("t038_rf_we", rf_we, 1);
    check("t038_pend_still", pending, 32'h80);
    step();
    check("t038_pend_clr", pending, 0);

    // re-issue during commit: set wins
    issue_valid = 1'b1; issue_rd = 5'd7;
    step(); idle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h99;
    step(); idle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step(); idle();
    check("t039_pend_kept", pending, 32'h80);

    // flush with outstanding request and a same-cycle issue
    for (int r = 4; r < 7; r++) begin
      issue_valid = 1'b1; issue_rd = 5'(r);
      step();
    end
    idle();
    step();
    check("t040_pend_f0", pending, 32'hF0);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9999;
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
    #1 check("t040_alu_ready_flush", alu_ready, 0);
    step();
    flush = 1'b0; issue_valid = 1'b0;
    check("t040_pend_zero", pending, 0);
    check("t040_no_we", rf_we, 0);
    #1 check("t040_alu_ready_after", alu_ready, 1);
    step(); idle();
    check("t040_late_we", rf_we, 1);
    check("t040_late_addr", rf_waddr, 9);
    // write already registered survives a flush in its cycle
    flush = 1'b1;
    #1 check("t025_we_in_flush", rf_we, 1);
    step(); idle();
    check("t025_we_after_flush", rf_we, 0);

    // reset between accept and commit
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
    issue_valid = 1'b1; issue_rd = 5'd10;
    step(); idle();
    alu_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t041_rf_we", rf_we, 0);
    check("t041_rf_waddr", rf_waddr, 0);
    check("t041_rf_wdata", rf_wdata, 0);
    check("t041_pending", pending, 0);
    check("t041_alu_ready", alu_ready, 0);
    step(); idle(); step();
    reset_n = 1'b1;
    step(); step();
    check("t041_no_pulse", rf_we, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, architectural register count; address width is 5.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports alu_valid  input  1, alu_rd  input  5 and alu_data  input  XLEN: ALU write-back request.
REQ-006 SHALL have port alu_ready  output  1  asserted in the cycle the ALU request is accepted.
REQ-007 SHALL have ports lsu_valid  input  1, lsu_rd  input  5 and lsu_data  input  XLEN: load-unit write-back request.
REQ-008 SHALL have port lsu_ready  output  1  asserted in the cycle the LSU request is accepted.
REQ-009 SHALL have ports issue_valid  input  1 and issue_rd  input  5: an instruction issued that will write issue_rd.
REQ-010 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-011 SHALL have ports rf_we  output  1, rf_waddr  output  5 and rf_wdata  output  XLEN: register-file write port drive.
REQ-012 SHALL have port pending  output  NREGS  per-register outstanding-write scoreboard.

Function
REQ-013 Accept = valid && ready; ready SHALL be combinational from the valids and the round-robin pointer, and SHALL never depend on data.
REQ-014 Only one valid: that requester SHALL be granted in the same cycle.
REQ-015 Both valid: the requester not granted most recently SHALL be granted; the loser's ready SHALL be 0 and it SHALL hold its request.
REQ-016 The pointer last_grant SHALL update only on an accepted request.
REQ-017 An accepted request SHALL appear on rf_we/rf_waddr/rf_wdata exactly one cycle later, as registered outputs.
REQ-018 With no accept, rf_we SHALL be 0 the next cycle; rf_waddr and rf_wdata SHALL hold their last values.
REQ-019 An accepted request with rd = 0 SHALL be consumed with ready = 1 but SHALL produce rf_we = 0.
REQ-020 issue_valid with issue_rd != 0 SHALL set pending[issue_rd] at the next edge.
REQ-021 A committed write (rf_we = 1) SHALL clear pending[rf_waddr] at the next edge.
REQ-022 If a set and a clear target the same register in one cycle, the set SHALL win.
REQ-023 pending[0] SHALL always read 0.
REQ-024 flush SHALL clear all pending bits, force ready = 0 on both requesters, and force rf_we = 0 the next cycle.
REQ-025 A write already registered before flush SHALL still be driven in the flush cycle.
REQ-026 An issue in the same cycle as flush SHALL be ignored.

Reset
REQ-027 While reset_n = 0: rf_we = 0, rf_waddr = 0, rf_wdata = 0, pending = 0.
REQ-028 While reset_n = 0, last_grant SHALL equal LSU, so the ALU wins the first contention.
REQ-029 Reset assertion SHALL take effect immediately, without a clock.
REQ-030 Reset mid-operation SHALL discard any in-flight write; no rf_we pulse SHALL occur after release until a new accept.
REQ-031 alu_ready and lsu_ready SHALL be 0 while reset_n = 0.

Structure
REQ-032 A shared package SHALL hold XLEN, NREGS, REG_AW = 5 and the requester enum {REQ_ALU, REQ_LSU}.
REQ-033 The scoreboard (REQ-020..023 and the clear part of REQ-024) SHALL be a separate sub-module, wb_scoreboard.
REQ-034 Arbitration and the output register SHALL stay in wb_arbiter.

Verification
REQ-035 After reset, alu_valid with rd = 5, data = 0xDEADBEEF -> alu_ready = 1 same cycle; next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF.
REQ-036 Both valid for 4 cycles (ALU rd = 1, LSU rd = 2, each dropping valid after acceptance, then reasserting) -> grants ALU, LSU, ALU, LSU; each loser holds.
REQ-037 LSU request with rd = 0, data = 0x1234 -> lsu_ready = 1, rf_we stays 0; pending unchanged.
REQ-038 Issue rd = 7 -> pending[7] = 1; a later ALU write to rd 7 -> pending[7] = 0 the cycle after rf_we.
REQ-039 A new issue rd = 7 in the same cycle as a committing write to 7 -> pending[7] stays 1.
REQ-040 Pending = 0x0000_00F0 with an ALU request outstanding, then flush -> pending = 0, alu_ready = 0, and no spurious rf_we.
REQ-041 reset_n dropped between accept and commit -> rf_we never pulses; all outputs are 0 asynchronously.
